// File: rtl/pwm_pkg.sv
// Shared PWM constants and measurement FSM state type; the generator and the
// receiver take their defaults from here so both agree on the frame length.
package pwm_pkg;

    localparam int PWM_CNT_W   = 9;
    localparam int PWM_TIMEOUT = 511;
    localparam int PWM_FRAME   = 256;

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        LOW
    } meas_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchroniser for an asynchronous PWM line plus an edge register.
// o_ready rises once the synchroniser holds real samples after reset.
module pwm_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o,
    output logic ready_o
);

    logic       r_meta;
    logic       r_s;
    logic       r_d;
    logic [1:0] r_fill;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= 1'b0;
            r_s    <= 1'b0;
            r_d    <= 1'b0;
            r_fill <= 2'b00;
        end else begin
            r_meta <= pwm_i;
            r_s    <= r_meta;
            r_d    <= r_s;
            r_fill <= {r_fill[0], 1'b1};
        end
    end

    assign s_o     = r_s;
    assign rise_o  = r_s & ~r_d;
    assign fall_o  = ~r_s & r_d;
    assign ready_o = r_fill[1];

endmodule

// File: rtl/pwm_meas.sv
// PWM receiver: measures high time and period of an asynchronous PWM input in
// clk_i cycles and flags lines stuck high or low for TIMEOUT cycles.
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int CNT_W   = PWM_CNT_W,
    parameter int TIMEOUT = PWM_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             stuck_hi_o,
    output logic             stuck_lo_o
);

    localparam logic [CNT_W-1:0] LP_TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TMO_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic             w_ready;
    logic             w_edge;

    meas_state_t      r_state;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_tcnt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_stuck_hi;
    logic             r_stuck_lo;

    pwm_sync_edge u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .pwm_i   (pwm_i),
        .s_o     (w_s),
        .rise_o  (w_rise),
        .fall_o  (w_fall),
        .ready_o (w_ready)
    );

    assign w_edge = w_rise | w_fall;

    // WAIT_LOW waits for a genuine synchronised low, so a line already high at
    // reset release never yields a partial first pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= WAIT_LOW;
            r_hcnt   <= '0;
            r_pcnt   <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                WAIT_LOW: begin
                    if (w_ready && !w_s) begin
                        r_state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_hcnt  <= LP_ONE;
                        r_pcnt  <= LP_ONE;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (r_pcnt == LP_TMO) begin
                        r_state <= WAIT_LOW;
                    end else if (w_fall) begin
                        r_pcnt  <= r_pcnt + 1'b1;
                        r_state <= LOW;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_high   <= r_hcnt;
                        r_period <= r_pcnt;
                        r_valid  <= 1'b1;
                        r_hcnt   <= LP_ONE;
                        r_pcnt   <= LP_ONE;
                        r_state  <= HIGH;
                    end else if (r_pcnt == LP_TMO) begin
                        r_state <= WAIT_RISE;
                    end else begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                default: r_state <= WAIT_LOW;
            endcase
        end
    end

    // Flags are raised on the same edge tcnt saturates at TIMEOUT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tcnt     <= '0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
        end else if (w_edge) begin
            r_tcnt     <= '0;
            r_stuck_hi <= 1'b0;
            r_stuck_lo <= 1'b0;
        end else if (r_tcnt != LP_TMO) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == LP_TMO_M1) begin
                r_stuck_hi <= w_s;
                r_stuck_lo <= ~w_s;
            end
        end
    end

    assign high_o     = r_high;
    assign period_o   = r_period;
    assign valid_o    = r_valid;
    assign stuck_hi_o = r_stuck_hi;
    assign stuck_lo_o = r_stuck_lo;

endmodule

// File: tb/tb_pwm_meas.sv
// Directed bench for pwm_meas: expected measurements are queued when each
// rising edge is driven and checked when valid_o pulses.
module tb_pwm_meas;

    localparam int T = 511;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] per;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm = 1'b0;
    logic [8:0] high_o;
    logic [8:0] period_o;
    logic       valid_o;
    logic       stuck_hi_o;
    logic       stuck_lo_o;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_valid  = 0;
    int   prev_hi  = 0;
    int   prev_per = 0;
    bit   in_meas  = 1'b0;

    pwm_meas dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .pwm_i      (pwm),
        .high_o     (high_o),
        .period_o   (period_o),
        .valid_o    (valid_o),
        .stuck_hi_o (stuck_hi_o),
        .stuck_lo_o (stuck_lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The period that ended just before this rise is reported at this rise.
    task automatic rise_model();
        exp_t e;
        if (in_meas && prev_per <= T) begin
            e.hi  = 32'(prev_hi);
            e.per = 32'(prev_per);
            q.push_back(e);
            n_push++;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        rise_model();
        pwm = 1'b1;
        wait_cyc(hi);
        pwm = 1'b0;
        wait_cyc(lo);
        prev_hi  = hi;
        prev_per = hi + lo;
        in_meas  = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid_o === 1'b1) begin
            exp_t e;
            n_valid++;
            chk("valid_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("high_o", 32'(high_o), e.hi);
                chk("period_o", 32'(period_o), e.per);
                chk("stuck_at_valid", 32'({stuck_hi_o, stuck_lo_o}), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        pwm = 1'b0;
        wait_cyc(3);
        chk("rst_high_o", 32'(high_o), 0);
        chk("rst_period_o", 32'(period_o), 0);
        chk("rst_valid_o", 32'(valid_o), 0);
        chk("rst_stuck_hi", 32'(stuck_hi_o), 0);
        chk("rst_stuck_lo", 32'(stuck_lo_o), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Duty 64 of a 256 frame.
        repeat (5) pulse(64, 192);
        chk("duty64_no_stuck", 32'({stuck_hi_o, stuck_lo_o}), 0);

        // Narrowest high, then narrowest low.
        repeat (3) pulse(1, 255);
        repeat (3) pulse(255, 1);

        // Line held low for 600 cycles after a high pulse.
        rise_model();
        pwm = 1'b1;
        wait_cyc(64);
        pwm = 1'b0;
        wait_cyc(T + 2);
        chk("stuck_lo_before", 32'(stuck_lo_o), 0);
        wait_cyc(1);
        chk("stuck_lo_set", 32'(stuck_lo_o), 1);
        chk("stuck_hi_clear_lo", 32'(stuck_hi_o), 0);
        wait_cyc(600 - T - 3);
        prev_hi  = 64;
        prev_per = 664;
        in_meas  = 1'b1;
        rise_model();
        pwm = 1'b1;
        wait_cyc(2);
        chk("stuck_lo_hold", 32'(stuck_lo_o), 1);
        wait_cyc(1);
        chk("stuck_lo_cleared", 32'(stuck_lo_o), 0);
        wait_cyc(61);
        pwm = 1'b0;
        wait_cyc(192);
        prev_hi  = 64;
        prev_per = 256;
        repeat (2) pulse(64, 192);

        // Constant high (duty 256), then back to duty 128.
        rise_model();
        pwm = 1'b1;
        wait_cyc(T + 2);
        chk("stuck_hi_before", 32'(stuck_hi_o), 0);
        wait_cyc(1);
        chk("stuck_hi_set", 32'(stuck_hi_o), 1);
        chk("stuck_lo_clear_hi", 32'(stuck_lo_o), 0);
        wait_cyc(600 - T - 3);
        pwm = 1'b0;
        wait_cyc(2);
        chk("stuck_hi_hold", 32'(stuck_hi_o), 1);
        wait_cyc(1);
        chk("stuck_hi_cleared", 32'(stuck_hi_o), 0);
        wait_cyc(125);
        prev_hi  = 600;
        prev_per = 728;
        in_meas  = 1'b1;
        repeat (3) pulse(128, 128);

        // Final rise flushes the last 128/256 period, then reset mid-HIGH.
        rise_model();
        pwm = 1'b1;
        wait_cyc(10);
        chk("queue_drained_pre_reset", 32'(q.size()), 0);
        chk("pre_reset_high_o", 32'(high_o), 128);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_high_o", 32'(high_o), 0);
        chk("async_rst_period_o", 32'(period_o), 0);
        chk("async_rst_flags", 32'({valid_o, stuck_hi_o, stuck_lo_o}), 0);
        q.delete();
        in_meas = 1'b0;
        wait_cyc(2);
        rst = 1'b0;

        // Input already high at reset release; 10 high / 20 low afterwards.
        wait_cyc(8);
        pwm = 1'b0;
        wait_cyc(20);
        chk("no_partial_valid", 32'(n_valid), 32'(n_push));
        repeat (4) pulse(10, 20);

        // 300/300 exceeds TIMEOUT: aborted, never reported, no stuck flags.
        repeat (3) pulse(300, 300);
        chk("long_period_no_stuck", 32'({stuck_hi_o, stuck_lo_o}), 0);
        wait_cyc(5);
        chk("queue_drained_end", 32'(q.size()), 0);
        chk("valid_count", 32'(n_valid), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
